// File: rtl/icache_responder_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_responder_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned WordWidth = 32;
    localparam int unsigned DefIndex  = 3;
    localparam int unsigned DefOffset = 5;

    typedef enum logic {
        Idle,
        Fill
    } icache_state_t;

    function automatic int unsigned tag_width(input int unsigned s_index,
                                              input int unsigned s_offset);
        return AddrWidth - s_index - s_offset;
    endfunction

    function automatic int unsigned line_width(input int unsigned s_offset);
        return 8 << s_offset;
    endfunction

    localparam int unsigned DefTagWidth  = tag_width(DefIndex, DefOffset);
    localparam int unsigned DefLineWidth = line_width(DefOffset);

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-port and line-fill port bundle; slave is the cache's view.
interface icache_responder_if
    import icache_responder_pkg::*;
#(
    parameter int unsigned LineWidth = DefLineWidth
);
    logic                 inst_read;
    logic [AddrWidth-1:0] inst_addr;
    logic                 inst_resp;
    logic [WordWidth-1:0] inst_rdata;
    logic                 pmem_read;
    logic [AddrWidth-1:0] pmem_address;
    logic [LineWidth-1:0] pmem_rdata;
    logic                 pmem_resp;

    modport master (
        output inst_read, inst_addr, pmem_rdata, pmem_resp,
        input  inst_resp, inst_rdata, pmem_read, pmem_address
    );

    modport slave (
        input  inst_read, inst_addr, pmem_rdata, pmem_resp,
        output inst_resp, inst_rdata, pmem_read, pmem_address
    );
endinterface

// File: rtl/icache_array.sv
// Register array: asynchronous read, synchronous write, synchronous active-low clear.
module icache_array #(
    parameter  int unsigned Width = 1,
    parameter  int unsigned Depth = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);
    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line fills on miss.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int unsigned S_INDEX  = DefIndex,
    parameter int unsigned S_OFFSET = DefOffset
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_responder_if.slave    bus,
    output logic [31:0]          miss_count
);
    localparam int unsigned TagW  = tag_width(S_INDEX, S_OFFSET);
    localparam int unsigned LineW = line_width(S_OFFSET);
    localparam int unsigned WselW = S_OFFSET - 2;
    localparam int unsigned Words = LineW / WordWidth;
    localparam int unsigned Sets  = 1 << S_INDEX;

    logic [TagW-1:0]    req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [WselW-1:0]   req_word;

    icache_state_t      state_q;
    logic               pmem_read_q;
    logic [TagW-1:0]    fill_tag_q;
    logic [S_INDEX-1:0] fill_idx_q;
    logic [31:0]        miss_count_q;

    logic                            valid_rd;
    logic [TagW-1:0]                 tag_rd;
    logic [LineW-1:0]                line_rd;
    logic [Words-1:0][WordWidth-1:0] line_words;
    logic                            hit;
    logic                            fill_we;
    logic                            unused_addr;

    assign req_tag     = bus.inst_addr[AddrWidth-1 -: TagW];
    assign req_idx     = bus.inst_addr[S_OFFSET +: S_INDEX];
    assign req_word    = bus.inst_addr[2 +: WselW];
    assign unused_addr = ^bus.inst_addr[1:0];

    // Reset wins over a same-edge fill so a cancelled fill leaves nothing behind.
    assign fill_we = (state_q == Fill) && bus.pmem_resp && rst;

    icache_array #(.Width(1), .Depth(Sets)) u_valid (
        .clk   (clk),
        .clr_n (rst),
        .we    (fill_we),
        .waddr (fill_idx_q),
        .wdata (1'b1),
        .raddr (req_idx),
        .rdata (valid_rd)
    );

    icache_array #(.Width(TagW), .Depth(Sets)) u_tag (
        .clk   (clk),
        .clr_n (1'b1),
        .we    (fill_we),
        .waddr (fill_idx_q),
        .wdata (fill_tag_q),
        .raddr (req_idx),
        .rdata (tag_rd)
    );

    icache_array #(.Width(LineW), .Depth(Sets)) u_data (
        .clk   (clk),
        .clr_n (1'b1),
        .we    (fill_we),
        .waddr (fill_idx_q),
        .wdata (bus.pmem_rdata),
        .raddr (req_idx),
        .rdata (line_rd)
    );

    assign line_words = line_rd;
    assign hit = bus.inst_read && (state_q == Idle) && valid_rd && (tag_rd == req_tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= Idle;
            pmem_read_q  <= 1'b0;
            fill_tag_q   <= '0;
            fill_idx_q   <= '0;
            miss_count_q <= '0;
        end else begin
            unique case (state_q)
                Idle: begin
                    if (bus.inst_read && !hit) begin
                        state_q     <= Fill;
                        pmem_read_q <= 1'b1;
                        fill_tag_q  <= req_tag;
                        fill_idx_q  <= req_idx;
                    end
                end
                Fill: begin
                    if (bus.pmem_resp) begin
                        state_q      <= Idle;
                        pmem_read_q  <= 1'b0;
                        miss_count_q <= miss_count_q + 32'd1;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign bus.inst_resp    = hit;
    assign bus.inst_rdata   = hit ? line_words[req_word] : '0;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_address = {fill_tag_q, fill_idx_q, {S_OFFSET{1'b0}}};
    assign miss_count       = miss_count_q;
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench: directed scenarios plus random fetches against a tag-only cache model.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    // Reference model: which line address each set holds, and the fill count.
    bit          m_valid [8];
    logic [23:0] m_tag   [8];
    int unsigned m_count;

    icache_responder_if #(.LineWidth(256)) bus ();

    icache_responder #(.S_INDEX(3), .S_OFFSET(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Backing memory contents; line 0x60 holds 0xA000_0000 + k in word k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        return (32'hA000_0000 ^ ((la ^ 32'h60) << 3)) + {29'd0, a[4:2]};
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_word(la + 32'(4 * k));
        return l;
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        bus.inst_read = 1'b0;
        bus.pmem_resp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_count = 0;
    endtask

    // One fetch from request to served word; serves the fill with 'lat' pmem_read cycles.
    task automatic access(input logic [31:0] addr, input int lat);
        int          idx;
        logic [23:0] tg;
        bit          exp_hit;
        idx = int'(addr[7:5]);
        tg  = addr[31:8];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        bus.inst_read = 1'b1;
        bus.inst_addr = addr;
        #1;
        if (exp_hit) begin
            checks++;
            if (bus.inst_resp !== 1'b1 || bus.inst_rdata !== mem_word(addr)) begin
                errors++;
                $display("FAIL hit %h: resp=%b data=%h, expected resp=1 data=%h",
                         addr, bus.inst_resp, bus.inst_rdata, mem_word(addr));
            end
            checks++;
            if (bus.pmem_read !== 1'b0) begin
                errors++;
                $display("FAIL hit_no_fill %h: pmem_read=%b, expected 0", addr, bus.pmem_read);
            end
            @(posedge clk); #1;
        end else begin
            checks++;
            if (bus.inst_resp !== 1'b0 || bus.inst_rdata !== 32'h0) begin
                errors++;
                $display("FAIL miss_quiet %h: resp=%b data=%h, expected resp=0 data=0",
                         addr, bus.inst_resp, bus.inst_rdata);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.pmem_read !== 1'b1 || bus.pmem_address !== {addr[31:5], 5'b0}) begin
                errors++;
                $display("FAIL fill_req %h: pmem_read=%b addr=%h, expected 1 %h", addr,
                         bus.pmem_read, bus.pmem_address, {addr[31:5], 5'b0});
            end
            for (int c = 1; c < lat; c++) begin
                checks++;
                if (bus.inst_resp !== 1'b0 || bus.pmem_read !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_wait %h: resp=%b pmem_read=%b, expected 0 1", addr,
                             bus.inst_resp, bus.pmem_read);
                end
                @(posedge clk); #1;
            end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = mem_line({addr[31:5], 5'b0});
            #1;
            checks++;
            if (bus.inst_resp !== 1'b0) begin
                errors++;
                $display("FAIL resp_in_fill %h: resp=%b, expected 0", addr, bus.inst_resp);
            end
            @(posedge clk); #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = '0;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_count++;
            #1;
            checks++;
            if (bus.inst_resp !== 1'b1 || bus.inst_rdata !== mem_word(addr) ||
                bus.pmem_read !== 1'b0) begin
                errors++;
                $display("FAIL fill_served %h: resp=%b data=%h pmem_read=%b, expected 1 %h 0",
                         addr, bus.inst_resp, bus.inst_rdata, bus.pmem_read, mem_word(addr));
            end
            checks++;
            if (miss_count !== m_count) begin
                errors++;
                $display("FAIL miss_count %h: got %0d expected %0d", addr, miss_count, m_count);
            end
            @(posedge clk); #1;
        end
        bus.inst_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h64;
        @(posedge clk); #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.inst_resp !== 1'b0 || bus.inst_rdata !== 32'h0 ||
            miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: pmem_read=%b resp=%b data=%h count=%0d, expected 0 0 0 0",
                     bus.pmem_read, bus.inst_resp, bus.inst_rdata, miss_count);
        end
        apply_reset();
    endtask

    task automatic test_cold_miss();
        apply_reset();
        access(32'h64, 3);
        checks++;
        if (miss_count !== 32'd1) begin
            errors++;
            $display("FAIL cold_count: got %0d expected 1", miss_count);
        end
        access(32'h68, 1);
    endtask

    task automatic test_conflict();
        apply_reset();
        access(32'h000, 2);
        access(32'h100, 2);
        access(32'h000, 2);
        checks++;
        if (miss_count !== 32'd3) begin
            errors++;
            $display("FAIL conflict_count: got %0d expected 3", miss_count);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h40;
        @(posedge clk); #1;
        bus.inst_addr = 32'h80;
        for (int c = 0; c < 3; c++) begin
            bus.inst_read = (c != 1);
            #1;
            checks++;
            if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h40 || bus.inst_resp !== 1'b0) begin
                errors++;
                $display("FAIL redirect_hold: pmem_read=%b addr=%h resp=%b, expected 1 00000040 0",
                         bus.pmem_read, bus.pmem_address, bus.inst_resp);
            end
            @(posedge clk); #1;
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = mem_line(32'h40);
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b0;
        m_valid[2] = 1'b1;
        m_tag[2]   = 24'h0;
        m_count++;
        access(32'h80, 2);
        access(32'h44, 1);
    endtask

    task automatic test_reset_mid_fill();
        apply_reset();
        bus.inst_read = 1'b1;
        bus.inst_addr = 32'h24;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.inst_read = 1'b0;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.inst_resp !== 1'b0 || bus.inst_rdata !== 32'h0 ||
            miss_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: pmem_read=%b resp=%b data=%h count=%0d, expected 0 0 0 0",
                     bus.pmem_read, bus.inst_resp, bus.inst_rdata, miss_count);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = mem_line(32'h20);
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        checks++;
        if (miss_count !== 32'd0 || bus.pmem_read !== 1'b0 || bus.inst_resp !== 1'b0) begin
            errors++;
            $display("FAIL stale_resp: count=%0d pmem_read=%b resp=%b, expected 0 0 0",
                     miss_count, bus.pmem_read, bus.inst_resp);
        end
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_count = 0;
        access(32'h24, 2);
    endtask

    task automatic test_streaming();
        access(32'h0, 1);
        for (int w = 0; w < 8; w++) begin
            bus.inst_read = 1'b1;
            bus.inst_addr = 32'(4 * w);
            #1;
            checks++;
            if (bus.inst_resp !== 1'b1 || bus.inst_rdata !== mem_word(32'(4 * w)) ||
                bus.pmem_read !== 1'b0) begin
                errors++;
                $display("FAIL stream word %0d: resp=%b data=%h pmem_read=%b, expected 1 %h 0",
                         w, bus.inst_resp, bus.inst_rdata, bus.pmem_read, mem_word(32'(4 * w)));
            end
            @(posedge clk); #1;
        end
        bus.inst_read = 1'b0;
    endtask

    task automatic test_random();
        logic [23:0] pool [3];
        logic [31:0] a;
        pool[0] = 24'h000000;
        pool[1] = 24'h00ABCD;
        pool[2] = 24'hF00001;
        for (int n = 0; n < 80; n++) begin
            a = {pool[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3))};
            access(a, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        bus.inst_read    = 1'b0;
        bus.inst_addr    = '0;
        bus.pmem_resp    = 1'b0;
        bus.pmem_rdata   = '0;
        m_count          = 0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_redirect();
        test_reset_mid_fill();
        test_streaming();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_responder.md
# icache_responder

Read-only, direct-mapped instruction cache answering the fetch stage's instruction port (`inst_read`/`inst_addr` → `inst_resp`/`inst_rdata`). On a hit it returns the 32-bit word combinationally in the request cycle. On a miss it fetches the full 256-bit line from physical memory, installs it, then answers. It sits between the IF stage and the memory arbiter / physical-memory port.

## Interface
- `S_INDEX`, default 3: index bits (8 sets).
- `S_OFFSET`, default 5: line-offset bits (32-byte line); tag width = 32 − `S_INDEX` − `S_OFFSET` (24 by default).

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low (asserted when 0)
- `inst_read`  in  1  fetch request, level-held until `inst_resp`
- `inst_addr`  in  32  fetch byte address; bits [1:0] ignored
- `inst_resp`  out  1  word valid this cycle
- `inst_rdata`  out  32  fetched word; 0 whenever `inst_resp`=0
- `pmem_read`  out  1  line-fill request, held until `pmem_resp`
- `pmem_address`  out  32  line address {tag, index, 5'b0}; stable while `pmem_read`=1
- `pmem_rdata`  in  256  line data, valid with `pmem_resp`
- `pmem_resp`  in  1  one-cycle fill completion
- `miss_count`  out  32  number of fills completed since reset; wraps at 2^32

## Operation
- Address split: tag = `inst_addr[31:8]`, index = `inst_addr[7:5]`, word = `inst_addr[4:2]`.
- Hit = `inst_read` & state==IDLE & valid[index] & (tag_array[index]==tag).
- FSM states:
  - IDLE → FILL when `inst_read` & !hit. Latch `pmem_address` = {tag, index, 5'b0} at that edge.
  - FILL → IDLE on `pmem_resp`. At the same edge: data[idx] ← `pmem_rdata`, tag[idx] ← latched tag, valid[idx] ← 1, `miss_count` += 1. The index and tag used are the latched ones, not the current `inst_addr`.
- `pmem_read` = (state==FILL).
- `inst_resp` is never asserted in FILL.
- Word select: `inst_rdata` = line[32·word +: 32].
- Fill replaces the indexed line unconditionally; no dirty state, no writes from the CPU side.

## Timing
- Hit latency 0: `inst_resp` in the same cycle as `inst_read`.
- Miss latency: N+1 cycles, where N is the number of cycles `pmem_read` is high up to and including the `pmem_resp` cycle. The word is served in IDLE on the cycle after `pmem_resp`.
- Reset (`rst`=0 at an edge), from any state, including mid-fill:
  - state → IDLE, all valid bits → 0, `miss_count` → 0.
  - Next cycle: `pmem_read`=0, `inst_resp`=0, `inst_rdata`=0.
  - Tag/data arrays are not cleared.
- A `pmem_resp` arriving in IDLE (e.g. a stale response after reset) is ignored: no array write, no count.
- `inst_addr` changes or `inst_read` drops during FILL (branch redirect):
  - The fill runs to completion with the latched address.
  - On return to IDLE the new address is looked up normally and may hit or start a new fill.
- Back-to-back hits are served every cycle.
- A miss in the cycle directly after a fill returns to IDLE enters FILL at that edge.

## Structure
- The shared types package carries `icache_state_t` (IDLE, FILL) and the tag/index/offset width constants derived from the parameters.
- One sub-module, `icache_array`: parameterized width × 2^`S_INDEX` register array with async read, sync write, and a synchronous active-low clear. Instantiate it three times: valid (width 1, cleared on reset), tag (width 24), data (width 256).
- The top level holds the FSM, the latched fill address, the comparator, the word mux, and `miss_count`.

## Test plan
- **Cold miss then hit.** Reset, then read 0x0000_0064 with memory line {word k = 0xA000_0000+k}, `pmem_resp` 3 cycles after `pmem_read` rises.
  - Required: `pmem_address`=0x0000_0060, `inst_resp` 1 cycle after `pmem_resp`, `inst_rdata`=0xA000_0001, `miss_count`=1.
  - Reread 0x0000_0068 → same-cycle resp, 0xA000_0002, no `pmem_read`.
- **Conflict eviction.** Fill 0x0000_0000, then read 0x0000_0100 (same index 0, different tag).
  - Required: new fill at 0x0000_0100. Rereading 0x0000_0000 misses again; `miss_count`=3.
- **Redirect mid-fill.** Miss on 0x0000_0040, then change `inst_addr` to 0x0000_0080 while in FILL.
  - Required: `pmem_address` stays 0x0000_0040. After `pmem_resp`, a second fill at 0x0000_0080. A later read of 0x0000_0040 hits.
- **Reset mid-fill.** Assert `rst`=0 during FILL, then deliver `pmem_resp` one cycle after reset is released.
  - Required: no `inst_resp`, `miss_count`=0, and a read of the same address misses (valid cleared).
- **Streaming hits.** After filling 0x0000_0000, present 8 consecutive word addresses, one per cycle.
  - Required: 8 consecutive `inst_resp` cycles with the matching words; `pmem_read` stays 0.
